// File: rtl/sig_gen_pkg.sv
// Shared constants, helpers and per-channel state type for the multi-channel
// signal generator.
package sig_gen_pkg;

    localparam int          AMP_W       = 16;
    localparam logic [31:0] LFSR_TAPS   = 32'h8020_0003;   // bits 31, 21, 1, 0
    localparam logic [31:0] RESET_SEED  = 32'hACE1_0001;
    localparam logic [31:0] GOLDEN_SEED = 32'h9E37_79B9;

    typedef struct packed {
        logic [31:0]      lfsr;
        logic [31:0]      counter;
        logic [AMP_W-1:0] amp;
        logic             pending;
    } chan_state_t;

    // One shift of the noise LFSR; feedback is the XOR of the tapped bits.
    function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
        return {cur[30:0], ^(cur & LFSR_TAPS)};
    endfunction

    // Three-term add clamped to a ceiling; operands are far below 2^32.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] c,
                                            input logic [31:0] limit);
        logic [31:0] sum;
        sum = a + b + c;
        return (sum > limit) ? limit : sum;
    endfunction

endpackage

// File: rtl/sig_gen_channel.sv
// One generator channel: LFSR noise, periodic/manual spike and exponential
// decay. The sample output is the value this channel would emit if loaded now;
// state moves on only when the arbiter strobes advance.
module sig_gen_channel
    import sig_gen_pkg::*;
#(
    parameter int                   ADC_WIDTH        = 12,
    parameter logic [ADC_WIDTH-1:0] BACKGROUND_LEVEL = 12'd2048,
    parameter int                   CH_INDEX         = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 seed_load,
    input  logic [31:0]          random_seed,
    input  logic                 advance,
    input  logic                 trigger,
    input  logic [ADC_WIDTH-1:0] noise_amplitude,
    input  logic [31:0]          spike_interval,
    input  logic [ADC_WIDTH-1:0] spike_amplitude,
    input  logic [2:0]           decay_shift,
    output logic [ADC_WIDTH-1:0] sample,
    output logic                 active
);

    localparam int          PROD_W     = 2 * ADC_WIDTH;
    localparam logic [31:0] SAMPLE_MAX = (32'd1 << ADC_WIDTH) - 32'd1;

    chan_state_t            state_r;
    chan_state_t            state_next_s;
    logic                   spike_s;
    logic [ADC_WIDTH-1:0]   amp_use_s;
    logic [ADC_WIDTH-1:0]   step_s;
    logic [ADC_WIDTH-1:0]   amp_next_s;
    logic [ADC_WIDTH-1:0]   noise_s;
    logic [PROD_W-1:0]      product_s;
    logic [31:0]            seed_raw_s;
    logic [31:0]            seed_s;

    // Spike decision, noise scaling, saturated sample and decayed amplitude
    always_comb begin
        spike_s    = state_r.pending ||
                     ((spike_interval != 32'd0) && (state_r.counter >= spike_interval));
        amp_use_s  = spike_s ? spike_amplitude : ADC_WIDTH'(state_r.amp);
        product_s  = PROD_W'(state_r.lfsr[ADC_WIDTH-1:0]) * PROD_W'(noise_amplitude);
        noise_s    = product_s[PROD_W-1:ADC_WIDTH];
        sample     = ADC_WIDTH'(sat_add(32'(BACKGROUND_LEVEL), 32'(amp_use_s),
                                        32'(noise_s), SAMPLE_MAX));
        step_s     = ((amp_use_s >> decay_shift) == '0) ? ADC_WIDTH'(1)
                                                         : (amp_use_s >> decay_shift);
        if (amp_use_s == '0) begin
            amp_next_s = '0;
        end else begin
            amp_next_s = amp_use_s - step_s;
        end
        seed_raw_s = random_seed ^ (32'(CH_INDEX) * GOLDEN_SEED);
        seed_s     = (seed_raw_s == 32'd0) ? 32'd1 : seed_raw_s;
    end

    // Next channel state: advance on load, latch triggers, reseed on request
    always_comb begin
        state_next_s = state_r;
        if (advance) begin
            state_next_s.lfsr = lfsr_next(state_r.lfsr);
            state_next_s.amp  = AMP_W'(amp_next_s);
            if (spike_s) begin
                state_next_s.counter = 32'd0;
            end else if (state_r.counter != 32'hFFFF_FFFF) begin
                state_next_s.counter = state_r.counter + 32'd1;
            end else begin
                state_next_s.counter = state_r.counter;
            end
        end else begin
            state_next_s.lfsr = state_r.lfsr;
        end
        // A trigger coinciding with consumption survives for the next sample.
        state_next_s.pending = trigger || (state_r.pending && !advance);
        if (seed_load) begin
            state_next_s.lfsr = seed_s;
        end else begin
            state_next_s.lfsr = state_next_s.lfsr;
        end
    end

    // Channel state register and its registered amplitude-nonzero flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= '{lfsr: RESET_SEED ^ 32'(CH_INDEX), counter: 32'd0,
                         amp: {AMP_W{1'b0}}, pending: 1'b0};
            active  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            active  <= (state_next_s.amp != {AMP_W{1'b0}});
        end
    end

endmodule

// File: rtl/multi_channel_signal_generator.sv
// Round-robin multi-channel signal generator: N independent channels feed one
// valid/ready sample stream tagged with the channel index.
module multi_channel_signal_generator
    import sig_gen_pkg::*;
#(
    parameter int                   ADC_WIDTH        = 12,
    parameter int                   NUM_CHANNELS     = 4,
    parameter logic [ADC_WIDTH-1:0] BACKGROUND_LEVEL = 12'd2048,
    parameter int                   CH_WIDTH         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    seed_load,
    input  logic [31:0]             random_seed,
    input  logic [ADC_WIDTH-1:0]    noise_amplitude,
    input  logic [31:0]             spike_interval,
    input  logic [ADC_WIDTH-1:0]    spike_amplitude,
    input  logic [2:0]              decay_shift,
    input  logic [NUM_CHANNELS-1:0] channel_mask,
    input  logic [NUM_CHANNELS-1:0] spike_trigger,
    output logic [ADC_WIDTH-1:0]    sample_data,
    output logic [CH_WIDTH-1:0]     sample_channel,
    output logic                    sample_valid,
    input  logic                    sample_ready,
    output logic [NUM_CHANNELS-1:0] spike_active
);

    logic [CH_WIDTH-1:0]     ptr_r;
    logic [CH_WIDTH-1:0]     sel_s;
    logic [CH_WIDTH-1:0]     cand_s;
    logic [CH_WIDTH:0]       idx_s;
    logic                    found_s;
    logic                    load_s;
    logic [NUM_CHANNELS-1:0] advance_s;
    logic [ADC_WIDTH-1:0]    ch_sample_s [NUM_CHANNELS];

    // Pick the first active channel at or after the pointer, with wrap-around
    always_comb begin
        sel_s   = '0;
        cand_s  = '0;
        idx_s   = '0;
        found_s = 1'b0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            idx_s = {1'b0, ptr_r} + (CH_WIDTH+1)'(i);
            if (idx_s >= (CH_WIDTH+1)'(NUM_CHANNELS)) begin
                idx_s = idx_s - (CH_WIDTH+1)'(NUM_CHANNELS);
            end else begin
                idx_s = idx_s;
            end
            cand_s = CH_WIDTH'(idx_s);
            if (!found_s && channel_mask[cand_s]) begin
                found_s = 1'b1;
                sel_s   = cand_s;
            end else begin
                found_s = found_s;
            end
        end
        load_s    = enable && found_s && (!sample_valid || sample_ready);
        advance_s = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            advance_s[c] = load_s && (sel_s == CH_WIDTH'(c));
        end
    end

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
        sig_gen_channel #(
            .ADC_WIDTH        (ADC_WIDTH),
            .BACKGROUND_LEVEL (BACKGROUND_LEVEL),
            .CH_INDEX         (g)
        ) u_ch (
            .clk             (clk),
            .rst_n           (rst_n),
            .seed_load       (seed_load),
            .random_seed     (random_seed),
            .advance         (advance_s[g]),
            .trigger         (spike_trigger[g]),
            .noise_amplitude (noise_amplitude),
            .spike_interval  (spike_interval),
            .spike_amplitude (spike_amplitude),
            .decay_shift     (decay_shift),
            .sample          (ch_sample_s[g]),
            .active          (spike_active[g])
        );
    end

    // Output register and round-robin pointer; output holds under backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_data    <= BACKGROUND_LEVEL;
            sample_channel <= '0;
            sample_valid   <= 1'b0;
            ptr_r          <= '0;
        end else if (load_s) begin
            sample_data    <= ch_sample_s[sel_s];
            sample_channel <= sel_s;
            sample_valid   <= 1'b1;
            ptr_r          <= (sel_s == CH_WIDTH'(NUM_CHANNELS - 1)) ? '0 : sel_s + CH_WIDTH'(1);
        end else if (sample_ready) begin
            sample_valid   <= 1'b0;
        end else begin
            sample_valid   <= sample_valid;
        end
    end

endmodule
